// File: rtl/slice_sum_stage.sv
// slice_sum_stage
//   Sums two 32-bit operands with a 16-bit and an 8-bit slice result. The sum
//   is registered in a single pipeline slot (S1), then queued in a small
//   result FIFO that is drained with a valid/ready handshake. A sticky flag
//   records any carry out of bit 31.
//
//   Optional feature: define SLICE_SUM_SAT_EN to saturate the result to
//   32'hFFFF_FFFF whenever the sum carries out. Without it the wrapped sum is
//   returned. The overflow flag behaves the same in both builds.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   eee       in   upstream valid
//   in_ready  out  a beat presented on eee is accepted this cycle
//   bus_out   in   [15:0] slice bus result, unsigned
//   w2        in   [7:0]  slice byte result, unsigned
//   x, y      in   [31:0] operands, unsigned
//   z_valid   out  result available at FIFO head
//   z_ready   in   downstream accepts the head result
//   z         out  [31:0] FIFO head result
//   ovf       out  sticky carry-out flag
//   ovf_clr   in   synchronous clear of ovf (a carry push on the same edge wins)
//   count     out  FIFO occupancy, 0..DEPTH
module slice_sum_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eee,
  output logic                     in_ready,
  input  logic [15:0]              bus_out,
  input  logic [7:0]               w2,
  input  logic [31:0]              x,
  input  logic [31:0]              y,
  output logic                     z_valid,
  input  logic                     z_ready,
  output logic [31:0]              z,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so count + s1_valid can never wrap before the compare.
  localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(DEPTH);

  logic          r_s1_valid;
  logic [31:0]   r_s1_data;
  logic          r_s1_carry;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic [33:0]   w_sum;
  logic          w_carry;
  logic [31:0]   w_result;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [AW+1:0] w_occupied;

  assign w_sum = {2'b00, x} + {2'b00, y} + {18'd0, bus_out} + {26'd0, w2};
  assign w_carry = |w_sum[33:32];

`ifdef SLICE_SUM_SAT_EN
  assign w_result = w_carry ? 32'hFFFF_FFFF : w_sum[31:0];
`else
  assign w_result = w_sum[31:0];
`endif

  // S1 plus the FIFO never hold more than DEPTH beats, so the S1 slot can
  // always drain into the FIFO on the next edge without a stall path.
  assign w_occupied = {1'b0, r_count} + {{(AW+1){1'b0}}, r_s1_valid};
  assign in_ready   = (w_occupied < LP_DEPTH);

  assign w_accept = eee && in_ready;
  assign w_push   = r_s1_valid;
  assign w_pop    = z_valid && z_ready;

  assign z_valid = (r_count != '0);
  assign z       = r_mem[r_rptr];
  assign ovf     = r_ovf;
  assign count   = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_carry <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data  <= w_result;
        r_s1_carry <= w_carry;
      end
    end
  end

  // Storage is intentionally not reset; entries are only read once counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_s1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_push && r_s1_carry) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slice_sum_stage.sv
module tb_slice_sum_stage;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        eee;
  logic        in_ready;
  logic [15:0] bus_out;
  logic [7:0]  w2;
  logic [31:0] x;
  logic [31:0] y;
  logic        z_valid;
  logic        z_ready;
  logic [31:0] z;
  logic        ovf;
  logic        ovf_clr;
  logic [$clog2(DEPTH):0] count;

  slice_sum_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .eee      (eee),
    .in_ready (in_ready),
    .bus_out  (bus_out),
    .w2       (w2),
    .x        (x),
    .y        (y),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z        (z),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic d1_v = 1'b0, d1_c = 1'b0, d2_v = 1'b0, d2_c = 1'b0;
  logic exp_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the full-width sum.
  function automatic exp_t model(input logic [31:0] xv, input logic [31:0] yv,
                                 input logic [15:0] bv, input logic [7:0] wv);
    exp_t e;
    longint unsigned s;
    s = 64'(xv) + 64'(yv) + 64'(bv) + 64'(wv);
    e.carry = (s > 64'h0000_0000_FFFF_FFFF);
`ifdef SLICE_SUM_SAT_EN
    e.data = e.carry ? 32'hFFFF_FFFF : s[31:0];
`else
    e.data = s[31:0];
`endif
    e.acc_cyc = 0;
    return e;
  endfunction

  // Called #1 after a rising edge; drives one cycle of stimulus and returns
  // #1 after the following rising edge.
  task automatic drive_cycle(input logic v, input logic [31:0] xv, input logic [31:0] yv,
                             input logic [15:0] bv, input logic [7:0] wv,
                             input logic zr, input logic clr);
    logic exp_ready;
    logic acc;
    exp_t e;
    exp_ready = (sb.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    eee = v; x = xv; y = yv; bus_out = bv; w2 = wv; z_ready = zr; ovf_clr = clr;
    acc = v && exp_ready;
    e = model(xv, yv, bv, wv);
    e.acc_cyc = cyc + 1;
    if (acc) sb.push_back(e);
    d2_v = d1_v; d2_c = d1_c;
    d1_v = acc;  d1_c = e.carry;
    @(posedge clk);
    #1;
    if (d2_v && d2_c) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  task automatic idle(input logic zr, input logic clr);
    drive_cycle(1'b0, 32'd0, 32'd0, 16'd0, 8'd0, zr, clr);
  endtask

  // Monitor: every falling edge compare occupancy and, on a handshake,
  // the head value against the oldest outstanding expected result.
  initial begin
    int n_in;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_in = 0;
        foreach (sb[i]) if (sb[i].acc_cyc + 1 <= cyc) n_in++;
        chk("count", 32'(count), 32'(n_in));
        chk("z_valid", {31'd0, z_valid}, {31'd0, (n_in != 0)});
        if (n_in != 0 && z_ready) begin
          chk("z", z, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic reset_mid();
    eee = 1'b0; z_ready = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_z_valid", {31'd0, z_valid}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    sb.delete();
    d1_v = 1'b0; d2_v = 1'b0; exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic [15:0] rb;
    logic [7:0]  rw;
    rst = 1'b0; eee = 1'b0; x = '0; y = '0; bus_out = '0; w2 = '0;
    z_ready = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("init_count", 32'(count), 32'd0);
    chk("init_z_valid", {31'd0, z_valid}, 32'd0);
    chk("init_ovf", {31'd0, ovf}, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single beat and its latency.
    drive_cycle(1'b1, 32'd1, 32'd2, 16'h0010, 8'h05, 1'b1, 1'b0);
    chk("single_lat1_z_valid", {31'd0, z_valid}, 32'd0);
    idle(1'b1, 1'b0);
    chk("single_lat2_z_valid", {31'd0, z_valid}, 32'd1);
    chk("single_z", z, 32'h18);
    idle(1'b1, 1'b0);
    chk("single_count_end", 32'(count), 32'd0);

    // Overflow, then clear.
    drive_cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 16'd0, 8'd0, 1'b1, 1'b0);
    idle(1'b0, 1'b0);
`ifdef SLICE_SUM_SAT_EN
    chk("ovf_z", z, 32'hFFFF_FFFF);
`else
    chk("ovf_z", z, 32'h0);
`endif
    idle(1'b1, 1'b0);
    repeat (3) idle(1'b0, 1'b0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    idle(1'b0, 1'b1);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // Backpressure: only DEPTH beats fit.
    for (int k = 1; k <= 6; k++)
      drive_cycle(1'b1, 32'(k), 32'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("bp_order", z, 32'(k));
      idle(1'b1, 1'b0);
    end
    idle(1'b1, 1'b0);
    chk("bp_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count=2 with S1 busy.
    for (int k = 0; k < 3; k++)
      drive_cycle(1'b1, 32'(100 + k), 32'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    for (int k = 3; k < 11; k++) begin
      drive_cycle(1'b1, 32'(100 + k), 32'd0, 16'd0, 8'd0, 1'b1, 1'b0);
      chk("pp_count", 32'(count), 32'd2);
    end
    repeat (4) idle(1'b1, 1'b0);
    chk("pp_drained", 32'(count), 32'd0);

    // Reset with three queued entries and S1 valid.
    for (int k = 0; k < 4; k++)
      drive_cycle(1'b1, 32'(200 + k), 32'd7, 16'd0, 8'd0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset_mid();
    repeat (3) idle(1'b1, 1'b0);
    chk("post_rst_z_valid", {31'd0, z_valid}, 32'd0);

    // Clear on the same edge as a carry push: set wins.
    drive_cycle(1'b1, 32'hFFFF_FFFF, 32'd5, 16'd0, 8'd0, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("race_ovf", {31'd0, ovf}, 32'd1);
    idle(1'b1, 1'b1);
    chk("race_ovf_clr", {31'd0, ovf}, 32'd0);
    idle(1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rx = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom();
      ry = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      rb = 16'($urandom());
      rw = 8'($urandom());
      drive_cycle(($urandom_range(0, 9) < 7), rx, ry, rb, rw,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
    end
    repeat (8) idle(1'b1, 1'b0);
    chk("final_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
